// File: rtl/pq_pkg.sv
// Shared HWPQ entry types: <key,value> entry, empty marker and capacity.
// Used by the arbiter, its interface and any HWPQ implementation.
package pq_pkg;

    localparam int KEY_WIDTH   = 8;
    localparam int VAL_WIDTH   = 8;
    localparam int PQ_CAPACITY = 8;

    typedef struct packed {
        logic [KEY_WIDTH-1:0] key;
        logic [VAL_WIDTH-1:0] value;
    } kv_t;

    localparam kv_t KV_EMPTY = '{key: '1, value: '0};

endpackage

// File: rtl/pq_arbiter_if.sv
// Bundle between NREQ requesters, the pq_arbiter and one HWPQ.
// master: arbiter view (drives ack/rsp_* and pq_* strobes/data);
// slave: client + PQ view (drives req_* and PQ status/head).
interface pq_arbiter_if #(
    parameter int NREQ = 4
);
    import pq_pkg::*;

    logic [NREQ-1:0]           req_enq;
    logic [NREQ-1:0]           req_deq;
    logic [NREQ*$bits(kv_t)-1:0] req_kv;
    logic [NREQ-1:0]           ack;
    kv_t                       rsp_kv;
    logic                      rsp_err;
    logic                      pq_enq;
    logic                      pq_deq;
    kv_t                       pq_kvin;
    kv_t                       pq_kvout;
    logic                      pq_busy;
    logic                      pq_empty;
    logic                      pq_full;

    modport master (
        input  req_enq, req_deq, req_kv,
        input  pq_kvout, pq_busy, pq_empty, pq_full,
        output ack, rsp_kv, rsp_err,
        output pq_enq, pq_deq, pq_kvin
    );

    modport slave (
        output req_enq, req_deq, req_kv,
        output pq_kvout, pq_busy, pq_empty, pq_full,
        input  ack, rsp_kv, rsp_err,
        input  pq_enq, pq_deq, pq_kvin
    );

endinterface

// File: rtl/pq_arbiter.sv
// Round-robin arbiter sharing one HWPQ among NREQ requesters, one command in flight.
// Ports: clk, rst (sync, active-high), bus (pq_arbiter_if.master: req_*, ack, rsp_*, pq_*).
// Optional macro PQ_ARB_REJECT_EN: ineligible requests are granted and acked with rsp_err=1.
module pq_arbiter
    import pq_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic         clk,
    input  logic         rst,
    pq_arbiter_if.master bus
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int KV_W  = $bits(kv_t);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_WAIT,
        S_ACK
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win_idx;
    logic [NREQ-1:0]  cand;
    logic             found;
    logic             win_enq;
    logic             grant;
    logic             op_enq;
    kv_t              kv_cap;

    logic [NREQ-1:0]  ack_q, ack_d;
    kv_t              rsp_kv_q, rsp_kv_d;
    logic             rsp_err_q, rsp_err_d;
    logic             pq_enq_q, pq_enq_d;
    logic             pq_deq_q, pq_deq_d;
    kv_t              pq_kvin_q, pq_kvin_d;

    // Candidates for the round-robin scan; enq has priority over deq
    // from the same requester.
    always_comb begin
        cand = '0;
        for (int i = 0; i < NREQ; i++) begin
`ifdef PQ_ARB_REJECT_EN
            cand[i] = bus.req_enq[i] | bus.req_deq[i];
`else
            cand[i] = bus.req_enq[i] ? !bus.pq_full
                                     : (bus.req_deq[i] & !bus.pq_empty);
`endif
        end
    end

    // First candidate after ptr, wrapping; ptr itself is checked last.
    always_comb begin
        found   = 1'b0;
        win_idx = ptr;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && cand[(int'(ptr) + k) % NREQ]) begin
                found   = 1'b1;
                win_idx = PTR_W'((int'(ptr) + k) % NREQ);
            end
        end
    end

    assign win_enq = bus.req_enq[win_idx];
    assign grant   = (state == S_IDLE) && !bus.pq_busy && found;

`ifdef PQ_ARB_REJECT_EN
    logic win_rej;
    assign win_rej = win_enq ? bus.pq_full : bus.pq_empty;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (grant) begin
`ifdef PQ_ARB_REJECT_EN
                    state_nx = win_rej ? S_ACK : S_CMD;
`else
                    state_nx = S_CMD;
`endif
                end
            end
            S_CMD:   state_nx = S_WAIT;
            S_WAIT:  if (!bus.pq_busy) state_nx = S_ACK;
            S_ACK:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs are registered, so their next values follow the transition.
    always_comb begin
        ack_d     = '0;
        pq_enq_d  = 1'b0;
        pq_deq_d  = 1'b0;
        pq_kvin_d = pq_kvin_q;
        rsp_kv_d  = rsp_kv_q;
        rsp_err_d = 1'b0;
        case (state)
            S_IDLE: begin
                if (state_nx == S_CMD) begin
                    pq_enq_d  = win_enq;
                    pq_deq_d  = !win_enq;
                    pq_kvin_d = bus.req_kv[int'(win_idx)*KV_W +: KV_W];
                end
                if (state_nx == S_ACK) begin
                    ack_d     = NREQ'(1) << win_idx;
                    rsp_err_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (state_nx == S_ACK) begin
                    ack_d = NREQ'(1) << ptr;
                    if (!op_enq) rsp_kv_d = kv_cap;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= PTR_W'(NREQ - 1);
            op_enq    <= 1'b0;
            kv_cap    <= KV_EMPTY;
            ack_q     <= '0;
            rsp_kv_q  <= KV_EMPTY;
            rsp_err_q <= 1'b0;
            pq_enq_q  <= 1'b0;
            pq_deq_q  <= 1'b0;
            pq_kvin_q <= KV_EMPTY;
        end else begin
            ack_q     <= ack_d;
            rsp_kv_q  <= rsp_kv_d;
            rsp_err_q <= rsp_err_d;
            pq_enq_q  <= pq_enq_d;
            pq_deq_q  <= pq_deq_d;
            pq_kvin_q <= pq_kvin_d;
            if (grant) begin
                ptr    <= win_idx;
                op_enq <= win_enq;
            end
            // Head is the entry being removed while the deq strobe is high.
            if (state == S_CMD && pq_deq_q) begin
                kv_cap <= bus.pq_kvout;
            end
        end
    end

    assign bus.ack     = ack_q;
    assign bus.rsp_kv  = rsp_kv_q;
    assign bus.rsp_err = rsp_err_q;
    assign bus.pq_enq  = pq_enq_q;
    assign bus.pq_deq  = pq_deq_q;
    assign bus.pq_kvin = pq_kvin_q;

endmodule
